// File: rtl/sm_pkg.sv
// Shared types and constants for the sign-magnitude add arbiter.
//   state_e     : sequencer states IDLE -> EXEC -> RESP
//   SM_W        : default operand width (1 sign bit + SM_W-1 magnitude bits)
//   req_id_t    : requester index (0 or 1)
//   pick_winner : round-robin choice between two requesters
package sm_pkg;

  localparam int SM_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic req_id_t;

  // On contention the requester that was not served last wins; a lone
  // request always wins. Only meaningful when at least one req is high.
  function automatic req_id_t pick_winner(input logic r0, input logic r1,
                                          input req_id_t last);
    req_id_t w;
    if (r0 && r1) begin
      w = ~last;
    end else if (r1) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational N-bit sign-magnitude adder.
//   a, b  : operands, bit N-1 = sign, bits N-2:0 = magnitude
//   sum   : sign-magnitude result, never negative zero
//   ovflw : carry out of the magnitude add (like signs only)
module sm_add_core
  import sm_pkg::*;
#(
  parameter int N = SM_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovflw
);

  logic [N-2:0] ma_s;
  logic [N-2:0] mb_s;
  logic         sa_s;
  logic         sb_s;
  logic [N-1:0] add_s;
  logic [N-2:0] mag_s;
  logic         sign_s;

  // Add magnitudes for like signs, subtract smaller from larger otherwise.
  always_comb begin
    ma_s   = a[N-2:0];
    mb_s   = b[N-2:0];
    sa_s   = a[N-1];
    sb_s   = b[N-1];
    add_s  = {1'b0, ma_s} + {1'b0, mb_s};
    mag_s  = {(N-1){1'b0}};
    sign_s = 1'b0;
    ovflw  = 1'b0;
    if (sa_s == sb_s) begin
      mag_s  = add_s[N-2:0];
      ovflw  = add_s[N-1];
      sign_s = sa_s;
    end else if (ma_s >= mb_s) begin
      mag_s  = ma_s - mb_s;
      sign_s = sa_s;
    end else begin
      mag_s  = mb_s - ma_s;
      sign_s = sb_s;
    end
    // A zero magnitude (exact cancel, wrapped overflow, -0 inputs) is +0.
    sum = {(mag_s != {(N-1){1'b0}}) & sign_s, mag_s};
  end

endmodule

// File: rtl/sm_add_arbiter.sv
// Two-requester round-robin front end for one shared sign-magnitude adder.
// Grant in IDLE captures the winner's operands, EXEC registers the sum,
// RESP issues a one-cycle done pulse (visible in the following cycle).
//   clk, rst          : clock, synchronous active-high reset
//   req0/a0/b0        : requester 0 level request and operands
//   req1/a1/b1        : requester 1 level request and operands
//   done0, done1      : one-cycle completion pulses
//   result, ovflw     : registered sum and overflow of the last op
//   busy              : high while an op is in EXEC or RESP
//   stats_clr         : synchronous clear of the op counters
//   op_cnt, ovf_cnt   : saturating counts of ops / overflowing ops
// Build option: define SM_ADD_STATS_EN to enable the counters; otherwise
// they read 0 and stats_clr is ignored.
module sm_add_arbiter
  import sm_pkg::*;
#(
  parameter int N     = SM_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [N-1:0]     a0,
  input  logic [N-1:0]     b0,
  input  logic             req1,
  input  logic [N-1:0]     a1,
  input  logic [N-1:0]     b1,
  output logic             done0,
  output logic             done1,
  output logic [N-1:0]     result,
  output logic             ovflw,
  output logic             busy,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  state_e       state_r;
  req_id_t      last_r;
  req_id_t      gnt_r;
  req_id_t      winner_s;
  logic [N-1:0] op_a_r;
  logic [N-1:0] op_b_r;
  logic [N-1:0] sum_s;
  logic         ovf_s;
  logic [N-1:0] result_r;
  logic         ovflw_r;
  logic         done0_r;
  logic         done1_r;
  logic         busy_r;

  assign winner_s = pick_winner(req0, req1, last_r);

  sm_add_core #(.N(N)) u_core (
    .a     (op_a_r),
    .b     (op_b_r),
    .sum   (sum_s),
    .ovflw (ovf_s)
  );

  // Sequencer: grant/capture, execute, respond; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      last_r   <= 1'b1;
      gnt_r    <= 1'b0;
      op_a_r   <= {N{1'b0}};
      op_b_r   <= {N{1'b0}};
      result_r <= {N{1'b0}};
      ovflw_r  <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          if (req0 || req1) begin
            gnt_r   <= winner_s;
            op_a_r  <= winner_s ? a1 : a0;
            op_b_r  <= winner_s ? b1 : b0;
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          result_r <= sum_s;
          ovflw_r  <= ovf_s;
          state_r  <= RESP;
        end
        RESP: begin
          // Pulse lands in the IDLE cycle that follows, where a still-high
          // req is arbitrated as a fresh request.
          done0_r <= ~gnt_r;
          done1_r <= gnt_r;
          last_r  <= gnt_r;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign done0  = done0_r;
  assign done1  = done1_r;
  assign result = result_r;
  assign ovflw  = ovflw_r;
  assign busy   = busy_r;

`ifdef SM_ADD_STATS_EN
  logic [CNT_W-1:0] op_cnt_r;
  logic [CNT_W-1:0] ovf_cnt_r;
  logic             resp_s;

  assign resp_s = (state_r == RESP);

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_r  <= {CNT_W{1'b0}};
      ovf_cnt_r <= {CNT_W{1'b0}};
    end else if (stats_clr) begin
      op_cnt_r  <= {CNT_W{1'b0}};
      ovf_cnt_r <= {CNT_W{1'b0}};
    end else if (resp_s) begin
      if (op_cnt_r != {CNT_W{1'b1}}) begin
        op_cnt_r <= op_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (ovflw_r && (ovf_cnt_r != {CNT_W{1'b1}})) begin
        ovf_cnt_r <= ovf_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign op_cnt  = op_cnt_r;
  assign ovf_cnt = ovf_cnt_r;
`else
  logic unused_stats_clr_s;

  assign unused_stats_clr_s = stats_clr;
  assign op_cnt             = {CNT_W{1'b0}};
  assign ovf_cnt            = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Scoreboard bench for sm_add_arbiter: drivers push expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_sm_add_arbiter;

  localparam int N     = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = 255;
`ifdef SM_ADD_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0, stats_clr = 1'b0;
  logic [N-1:0]     a0 = 5'd0, b0 = 5'd0, a1 = 5'd0, b1 = 5'd0;
  logic             done0, done1, ovflw, busy;
  logic [N-1:0]     result;
  logic [CNT_W-1:0] op_cnt, ovf_cnt;

  sm_add_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .ovflw(ovflw),
    .busy(busy), .stats_clr(stats_clr), .op_cnt(op_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [5:0] exp0_q[$];
  logic [5:0] exp1_q[$];
  bit         ord_q[$];
  int         mdl_op  = 0;
  int         mdl_ovf = 0;
  bit         last_id = 1'b1;
  bit         prev_rst = 1'b1;
  bit         prev_clr = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: signed integer arithmetic, then re-encode as sign-magnitude.
  function automatic logic [5:0] ref_add(input logic [4:0] a, input logic [4:0] b);
    int va, vb, s, m;
    bit neg, ov;
    va = int'(a[3:0]);
    if (a[4]) va = -va;
    vb = int'(b[3:0]);
    if (b[4]) vb = -vb;
    s   = va + vb;
    neg = (s < 0);
    m   = neg ? -s : s;
    ov  = (m > 15);
    m   = m % 16;
    if (m == 0) neg = 1'b0;
    return {ov, neg, m[3:0]};
  endfunction

  // Monitor: rst/stats_clr change only just after posedge, so the value read
  // at the previous negedge is what the DUT sampled at the last edge.
  always @(negedge clk) begin
    bit         edge_rst, edge_clr, id;
    logic [5:0] e;
    edge_rst = prev_rst;
    edge_clr = prev_clr;
    prev_rst = rst;
    prev_clr = stats_clr;
    if (edge_rst) begin
      mdl_op  = 0;
      mdl_ovf = 0;
      last_id = 1'b1;
    end else begin
      if (edge_clr) begin
        mdl_op  = 0;
        mdl_ovf = 0;
      end
      if (done0 && done1) begin
        chk_cnt++;
        $display("FAIL double_done: got done0=1 done1=1 expected one-hot");
      end else if (done0 || done1) begin
        id = done1;
        if ((id ? exp1_q.size() : exp0_q.size()) == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_done: got done%0d expected none", id);
        end else begin
          e = id ? exp1_q.pop_front() : exp0_q.pop_front();
          check(id ? "result1" : "result0", {ovflw, result}, e);
          if (STATS_EN && !edge_clr) begin
            if (mdl_op < CMAX) mdl_op++;
            if (e[5] && mdl_ovf < CMAX) mdl_ovf++;
          end
        end
        if (ord_q.size() > 0) check("grant_order", id, ord_q.pop_front());
        check("busy_at_done", busy, 1'b0);
        check("op_cnt", op_cnt, mdl_op);
        check("ovf_cnt", ovf_cnt, mdl_ovf);
        last_id = id;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    ord_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One request on one requester; also checks the 3-cycle latency.
  task automatic run_single(input bit id, input logic [4:0] a, input logic [4:0] b);
    int n;
    bit got;
    @(negedge clk);
    if (id) begin
      a1 = a; b1 = b; req1 = 1'b1; exp1_q.push_back(ref_add(a, b));
    end else begin
      a0 = a; b0 = b; req0 = 1'b1; exp0_q.push_back(ref_add(a, b));
    end
    n = 0;
    got = 1'b0;
    while (n < 12 && !got) begin
      @(negedge clk);
      n++;
      if (id ? done1 : done0) got = 1'b1;
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
    check("single_latency", n, 3);
  endtask

  // Both requesters hold req high for nops ops each, reloading operands on
  // their own done; grants must alternate starting from the one not last.
  task automatic run_both(input int nops);
    int  cyc, ndone, rem0, rem1;
    bit  w;
    @(negedge clk);
    w = ~last_id;
    rem0 = nops;
    rem1 = nops;
    a0 = 5'($urandom_range(0, 31)); b0 = 5'($urandom_range(0, 31));
    a1 = 5'($urandom_range(0, 31)); b1 = 5'($urandom_range(0, 31));
    exp0_q.push_back(ref_add(a0, b0));
    exp1_q.push_back(ref_add(a1, b1));
    for (int i = 0; i < 2 * nops; i++) ord_q.push_back((i % 2 == 0) ? w : ~w);
    req0 = 1'b1;
    req1 = 1'b1;
    cyc = 0;
    ndone = 0;
    while (ndone < 2 * nops && cyc < 6 * nops + 10) begin
      @(negedge clk);
      cyc++;
      if (done0 || done1) begin
        ndone++;
        check("done_spacing", cyc, 3 * ndone);
        if (done0) begin
          rem0--;
          if (rem0 > 0) begin
            a0 = 5'($urandom_range(0, 31)); b0 = 5'($urandom_range(0, 31));
            exp0_q.push_back(ref_add(a0, b0));
          end else req0 = 1'b0;
        end
        if (done1) begin
          rem1--;
          if (rem1 > 0) begin
            a1 = 5'($urandom_range(0, 31)); b1 = 5'($urandom_range(0, 31));
            exp1_q.push_back(ref_add(a1, b1));
          end else req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    ord_q.delete();
    check("contention_count", ndone, 2 * nops);
  endtask

  logic [4:0] edge_a [6] = '{5'b10111, 5'b11000, 5'b11001, 5'b01111, 5'b10000, 5'b00000};
  logic [4:0] edge_b [6] = '{5'b00111, 5'b11000, 5'b11001, 5'b00001, 5'b00000, 5'b10000};

  initial begin
    int nd;
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_result", result, 5'd0);
    check("rst_ovflw", ovflw, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_done1", done1, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_op_cnt", op_cnt, 8'd0);
    check("rst_ovf_cnt", ovf_cnt, 8'd0);

    // Contention straight out of reset: 0,1,0,1 at cycles 3,6,9,12
    run_both(2);

    // Single request and arithmetic edge cases
    do_reset();
    run_single(1'b0, 5'b00101, 5'b10011);
    for (int i = 0; i < 6; i++) run_single(1'b1, edge_a[i], edge_b[i]);

    // Statistics: 4 ops, 2 overflowing
    do_reset();
    run_single(1'b0, 5'b11000, 5'b11000);
    run_single(1'b1, 5'b01111, 5'b00001);
    run_single(1'b0, 5'b00101, 5'b10011);
    run_single(1'b1, 5'b10111, 5'b00111);
    @(negedge clk);
    check("stats_op4", op_cnt, STATS_EN ? 8'd4 : 8'd0);
    check("stats_ovf2", ovf_cnt, STATS_EN ? 8'd2 : 8'd0);
    @(posedge clk);
    #1 stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
    @(negedge clk);
    check("clr_op", op_cnt, 8'd0);
    check("clr_ovf", ovf_cnt, 8'd0);

    // Clear asserted in the RESP cycle must beat the increment
    run_single(1'b0, 5'b01000, 5'b01000);
    @(negedge clk);
    a0 = 5'b01000; b0 = 5'b01000; req0 = 1'b1;
    exp0_q.push_back(ref_add(a0, b0));
    @(posedge clk);
    @(posedge clk);
    #1 stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    check("clr_prio_done", done0, 1'b1);

    // Mid-operation reset in EXEC: abort silently, req0 priority restored
    @(negedge clk);
    a1 = 5'b00011; b1 = 5'b00001; req1 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_result", result, 5'd0);
    check("midrst_ovflw", ovflw, 1'b0);
    check("midrst_busy", busy, 1'b0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done0 || done1) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_both(1);

    // Randomized mix
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: run_single(1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        1: run_single(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        default: run_both(int'($urandom_range(1, 3)));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Long contention run drives the counters into saturation
    run_both(130);
    @(negedge clk);
    check("sat_op", op_cnt, STATS_EN ? 8'd255 : 8'd0);
    check("leftover_exp", exp0_q.size() + exp1_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
